// File: rtl/mio_bus_responder_if.sv
// CPU-side memory/IO bus between the CPU core and the responder.
// The master drives the request; the slave returns read data and the
// one-cycle completion pulse.
interface mio_bus_responder_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        mio_ready;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, mio_ready
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, mio_ready
    );
endinterface

// File: rtl/mio_bus_responder.sv
// Memory/IO responder for the multi-cycle CPU bus.
// Each CPU request is decoded into RAM space or IO space (addr[31:28] = E/F).
// The responder then steps through the wait states, returns the read data, and
// pulses mio_ready for one cycle.
// Optional build macro BUS_TIMEOUT_EN: an IO access that gets no io_ack within
// IO_TIMEOUT cycles is forced to complete. Reads then return 32'hDEAD_BEEF, and
// the sticky bus_err flag is set.
//
// state    | meaning
// IDLE     | waiting for cpu_req
// RAM_ACC  | RAM access in progress, RAM_WAIT cycles
// IO_WAIT  | peripheral selected, waiting for io_ack
// DONE     | mio_ready high for this single cycle
module mio_bus_responder #(
    parameter int RAM_AW     = 10,
    parameter int RAM_WAIT   = 1,
    parameter int IO_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    mio_bus_responder_if.slave bus,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_sel,
    output logic              io_we,
    output logic [27:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ack,
    output logic              bus_err
);
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] RAM_LOAD = CNT_W'(RAM_WAIT - 1);
`ifdef BUS_TIMEOUT_EN
    localparam logic [CNT_W-1:0] IO_LOAD = CNT_W'(IO_TIMEOUT - 1);
`else
    localparam int UNUSED_IO_TIMEOUT = IO_TIMEOUT;
`endif

    typedef enum logic [1:0] {IDLE, RAM_ACC, IO_WAIT, DONE} state_t;

    state_t           state;
    logic             we_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_io;
    logic             unused_addr_bits;

    // Word-aligned bus: the byte-lane bits carry no information.
    assign unused_addr_bits = ^bus.cpu_addr[1:0];

    // IO space occupies the top two 256 MB regions.
    assign is_io = (bus.cpu_addr[31:28] == 4'hE) || (bus.cpu_addr[31:28] == 4'hF);

`ifndef BUS_TIMEOUT_EN
    // Without the timeout there is no way to raise a bus error.
    assign bus_err = 1'b0;
`endif

    // Request sequencer; every bus-side output is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            wait_cnt      <= '0;
            bus.cpu_rdata <= 32'h0;
            bus.mio_ready <= 1'b0;
            ram_en        <= 1'b0;
            ram_we        <= 1'b0;
            ram_addr      <= '0;
            ram_wdata     <= 32'h0;
            io_sel        <= 1'b0;
            io_we         <= 1'b0;
            io_addr       <= 28'h0;
            io_wdata      <= 32'h0;
`ifdef BUS_TIMEOUT_EN
            bus_err       <= 1'b0;
`endif
        end else begin
            bus.mio_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        we_q <= bus.cpu_we;
                        if (is_io) begin
                            io_sel   <= 1'b1;
                            io_we    <= bus.cpu_we;
                            io_addr  <= bus.cpu_addr[27:0];
                            io_wdata <= bus.cpu_wdata;
`ifdef BUS_TIMEOUT_EN
                            wait_cnt <= IO_LOAD;
`endif
                            state    <= IO_WAIT;
                        end else begin
                            ram_en    <= 1'b1;
                            ram_we    <= bus.cpu_we;
                            ram_addr  <= bus.cpu_addr[RAM_AW+1:2];
                            ram_wdata <= bus.cpu_wdata;
                            wait_cnt  <= RAM_LOAD;
                            state     <= RAM_ACC;
                        end
                    end
                end
                RAM_ACC: begin
                    // The strobe covers only the first access cycle.
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    if (wait_cnt == '0) begin
                        if (!we_q) bus.cpu_rdata <= ram_rdata;
                        bus.mio_ready <= 1'b1;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                IO_WAIT: begin
                    if (io_ack) begin
                        io_sel <= 1'b0;
                        io_we  <= 1'b0;
                        if (!we_q) bus.cpu_rdata <= io_rdata;
                        bus.mio_ready <= 1'b1;
                        state         <= DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (wait_cnt == '0) begin
                        io_sel  <= 1'b0;
                        io_we   <= 1'b0;
                        if (!we_q) bus.cpu_rdata <= 32'hDEAD_BEEF;
                        bus_err       <= 1'b1;
                        bus.mio_ready <= 1'b1;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder: RAM write/read, IO read/write,
// IO stall or timeout (build dependent), stray io_ack, back-to-back requests
// and reset during an access. A small word memory answers the RAM port.
module tb_mio_bus_responder;
    localparam int RAM_WAIT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        io_sel, io_we;
    logic [27:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata = 32'h0;
    logic        io_ack = 1'b0;
    logic        bus_err;

    mio_bus_responder_if bus ();

    mio_bus_responder #(.RAM_AW(10), .RAM_WAIT(RAM_WAIT), .IO_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .io_sel(io_sel), .io_we(io_we), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Asynchronous-read word memory behind the RAM port.
    logic [31:0] mem [0:1023];
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;

    // Activity monitors.
    int          n_cmp = 0, n_err = 0;
    int          ready_pulses = 0, io_sel_cycles = 0, ram_en_cycles = 0;
    logic [9:0]  last_ram_addr;
    logic        last_ram_we;
    logic [31:0] last_ram_wdata;
    logic [27:0] last_io_addr;
    logic        last_io_we;
    logic [31:0] last_io_wdata;
    always @(posedge clk) begin
        if (bus.mio_ready) ready_pulses++;
        if (io_sel) begin
            io_sel_cycles++;
            last_io_addr  = io_addr;
            last_io_we    = io_we;
            last_io_wdata = io_wdata;
        end
        if (ram_en) begin
            ram_en_cycles++;
            last_ram_addr  = ram_addr;
            last_ram_we    = ram_we;
            last_ram_wdata = ram_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int max, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.mio_ready && cyc < max);
    endtask

    // One RAM transfer; called 1 time unit after a clock edge.
    task automatic ram_xfer(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata);
        int cyc;
        int p0;
        p0 = ready_pulses;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        wait_ready(10, cyc);
        chk({tag, "_ready"}, 32'(bus.mio_ready), 32'h1);
        chk({tag, "_lat"}, 32'(cyc), 32'(RAM_WAIT + 1));
        chk({tag, "_rdata"}, bus.cpu_rdata, exp_rdata);
        bus.cpu_req = 1'b0;
        tick();
        chk({tag, "_pulses"}, 32'(ready_pulses - p0), 32'h1);
    endtask

    // One IO transfer acknowledged after ack_delay cycles of io_sel.
    task automatic io_xfer(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_delay,
                           input logic [31:0] ack_data, input logic [31:0] exp_rdata);
        int p0;
        p0 = ready_pulses;
        io_sel_cycles = 0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        tick();
        chk({tag, "_sel"}, 32'(io_sel), 32'h1);
        chk({tag, "_addr"}, 32'(io_addr), {4'h0, addr[27:0]});
        chk({tag, "_we"}, 32'(io_we), 32'(we));
        chk({tag, "_wdata"}, io_wdata, wdata);
        repeat (ack_delay - 1) tick();
        chk({tag, "_early"}, 32'(bus.mio_ready), 32'h0);
        io_ack   = 1'b1;
        io_rdata = ack_data;
        tick();
        io_ack   = 1'b0;
        io_rdata = 32'h0;
        chk({tag, "_ready"}, 32'(bus.mio_ready), 32'h1);
        chk({tag, "_rdata"}, bus.cpu_rdata, exp_rdata);
        chk({tag, "_seloff"}, 32'(io_sel), 32'h0);
        bus.cpu_req = 1'b0;
        tick();
        chk({tag, "_selcyc"}, 32'(io_sel_cycles), 32'(ack_delay));
        chk({tag, "_pulses"}, 32'(ready_pulses - p0), 32'h1);
    endtask

    initial begin
        int p0;
        int cyc;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;

        // Reset state
        repeat (2) tick();
        chk("rst_ram_en", 32'(ram_en), 32'h0);
        chk("rst_io_sel", 32'(io_sel), 32'h0);
        chk("rst_ready", 32'(bus.mio_ready), 32'h0);
        chk("rst_rdata", bus.cpu_rdata, 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        reset = 1'b0;
        tick();

        // RAM write, then read back
        ram_en_cycles = 0;
        ram_xfer("wr10", 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0);
        chk("wr10_addr", 32'(last_ram_addr), 32'd4);
        chk("wr10_we", 32'(last_ram_we), 32'h1);
        chk("wr10_wdata", last_ram_wdata, 32'h1234_5678);
        chk("wr10_en_cyc", 32'(ram_en_cycles), 32'h1);
        chk("wr10_mem", mem[4], 32'h1234_5678);
        ram_xfer("rd10", 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678);
        chk("rd10_we", 32'(last_ram_we), 32'h0);

        // Stray io_ack while idle
        p0 = ready_pulses;
        io_ack   = 1'b1;
        io_rdata = 32'hFFFF_FFFF;
        tick();
        io_ack   = 1'b0;
        io_rdata = 32'h0;
        repeat (2) tick();
        chk("stray_pulses", 32'(ready_pulses - p0), 32'h0);
        chk("stray_rdata", bus.cpu_rdata, 32'h1234_5678);

        // IO read with a 5-cycle wait, then an IO write that leaves cpu_rdata alone
        io_xfer("iord", 1'b0, 32'hE000_0004, 32'h0, 5, 32'hA5A5_0001, 32'hA5A5_0001);
        io_xfer("iowr", 1'b1, 32'hF000_0100, 32'h0000_0055, 2, 32'h1111_1111, 32'hA5A5_0001);

`ifdef BUS_TIMEOUT_EN
        // IO read that never gets an ack: forced completion after 8 waits
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'hE000_0008;
        wait_ready(20, cyc);
        chk("tmo_ready", 32'(bus.mio_ready), 32'h1);
        chk("tmo_lat", 32'(cyc), 32'd9);
        chk("tmo_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
        chk("tmo_bus_err", 32'(bus_err), 32'h1);
        chk("tmo_seloff", 32'(io_sel), 32'h0);
        bus.cpu_req = 1'b0;
        repeat (3) tick();
        chk("tmo_sticky", 32'(bus_err), 32'h1);
`else
        // IO read that stalls: no completion until the peripheral answers
        p0 = ready_pulses;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'hE000_0008;
        repeat (30) tick();
        chk("stall_pulses", 32'(ready_pulses - p0), 32'h0);
        chk("stall_sel", 32'(io_sel), 32'h1);
        chk("stall_bus_err", 32'(bus_err), 32'h0);
        io_ack   = 1'b1;
        io_rdata = 32'h0000_0077;
        tick();
        io_ack = 1'b0;
        chk("stall_ready", 32'(bus.mio_ready), 32'h1);
        chk("stall_rdata", bus.cpu_rdata, 32'h0000_0077);
        bus.cpu_req = 1'b0;
        tick();
`endif

        // Back-to-back RAM requests
        p0 = ready_pulses;
        ram_xfer("b2b_rd", 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678);
        ram_xfer("b2b_wr", 1'b1, 32'h0000_0020, 32'hCAFE_0001, 32'h1234_5678);
        ram_xfer("b2b_rd2", 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_0001);
        chk("b2b_total", 32'(ready_pulses - p0), 32'd3);

        // Reset in the middle of a RAM access
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h0000_0040;
        bus.cpu_wdata = 32'h0BAD_0BAD;
        tick();
        chk("mid_ram_en", 32'(ram_en), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("mid_ram_en_clr", 32'(ram_en), 32'h0);
        chk("mid_ram_addr", 32'(ram_addr), 32'h0);
        chk("mid_ram_wdata", ram_wdata, 32'h0);
        chk("mid_rdata", bus.cpu_rdata, 32'h0);
        chk("mid_ready", 32'(bus.mio_ready), 32'h0);
        chk("mid_io_addr", 32'(io_addr), 32'h0);
        chk("mid_io_wdata", io_wdata, 32'h0);
        chk("mid_bus_err", 32'(bus_err), 32'h0);
        bus.cpu_req = 1'b0;
        p0 = ready_pulses;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        chk("mid_no_ready", 32'(ready_pulses - p0), 32'h0);
        chk("mid_idle_en", 32'(ram_en), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end
endmodule
